// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full adder (two half adders + OR) consumes operands
// LSB-first, one bit per clock, with the carry held in a flip-flop.
module serial_adder_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             busy,
  output logic [1:0]       state_dbg_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and ready is state-driven only.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             live_q;

  logic ha0_s, ha0_c, ha1_s, ha1_c;

  assign ha0_s = a_q[0] ^ b_q[0];
  assign ha0_c = a_q[0] & b_q[0];
  assign ha1_s = ha0_s ^ carry_q;
  assign ha1_c = ha0_s & carry_q;

  // live_q keeps in_ready low until the first edge after reset release.
  assign in_ready    = live_q && (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign sum_out     = sum_q;
  assign carry_out   = carry_q;
  assign state_dbg_o = state_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d   = {ha1_s, sum_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = ha0_c | ha1_c;
        // The edge that processes bit WIDTH-1 ends the op; counter holds.
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq: an 8-bit instance for the scenario
// tests and a 16-bit instance fed from a vector table with handshake gaps.
module tb_serial_adder_seq;

  logic clk;
  logic rst_n;

  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, carry8, busy8;
  logic [7:0]  a_in8, b_in8, sum8;
  logic [1:0]  state8;

  logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, carry16, busy16;
  logic [15:0] a_in16, b_in16, sum16;
  logic [1:0]  state16;

  int n_checks;
  int n_fail;
  logic [16:0] exp_q[$];

  serial_adder_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a_in(a_in8), .b_in(b_in8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum_out(sum8), .carry_out(carry8), .busy(busy8),
    .state_dbg_o(state8)
  );

  serial_adder_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .a_in(a_in16), .b_in(b_in16), .cin(cin16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .sum_out(sum16), .carry_out(carry16), .busy(busy16),
    .state_dbg_o(state16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready8 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a_in8 = a; b_in8 = b; cin8 = c; in_valid8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
  endtask

  // Edges counted from the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_done8(output int lat);
    lat = 1;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      if (!out_valid8) lat++;
    end
    if (!out_valid8) lat = -1;
  endtask

  task automatic finish_op8();
    @(negedge clk);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic start_op16(input logic [15:0] a, input logic [15:0] b, input logic c);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready16 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a_in16 = a; b_in16 = b; cin16 = c; in_valid16 = 1'b1;
    @(posedge clk);
    #1 in_valid16 = 1'b0;
  endtask

  task automatic wait_done16(output int lat);
    lat = 1;
    while (!out_valid16 && lat < 60) begin
      @(posedge clk); #1;
      if (!out_valid16) lat++;
    end
    if (!out_valid16) lat = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    n_checks++;
    if ({in_ready8, out_valid8, busy8, carry8} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/vld/busy/cy=%b want 0000", {in_ready8, out_valid8, busy8, carry8});
    end
    n_checks++;
    if (sum8 !== 8'h00 || state8 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got sum=%h state=%0d want sum=00 state=0", sum8, state8);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_before_edge: got %b want 0", in_ready8);
    end
    @(posedge clk); #1;
    n_checks++;
    if (in_ready8 !== 1'b1 || in_ready16 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_after_edge: got %b/%b want 1/1", in_ready8, in_ready16);
    end
  endtask

  task automatic test_basic();
    int lat;
    start_op8(8'h0F, 8'h01, 1'b0);
    wait_done8(lat);
    n_checks++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges want 8", lat);
    end
    n_checks++;
    if ({carry8, sum8} !== 9'h010) begin
      n_fail++;
      $display("FAIL basic_sum: got c=%b s=%h want c=0 s=10", carry8, sum8);
    end
    n_checks++;
    if (in_ready8 !== 1'b0 || busy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done_flags: got rdy=%b busy=%b want 0 1", in_ready8, busy8);
    end
    finish_op8();
    n_checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_return_idle: got vld=%b rdy=%b busy=%b want 0 1 0", out_valid8, in_ready8, busy8);
    end
  endtask

  task automatic test_carry();
    int lat;
    start_op8(8'hFF, 8'h01, 1'b0);
    wait_done8(lat);
    n_checks++;
    if (lat !== 8 || {carry8, sum8} !== 9'h100) begin
      n_fail++;
      $display("FAIL carry_ff_01: got lat=%0d c=%b s=%h want 8 1 00", lat, carry8, sum8);
    end
    finish_op8();
    start_op8(8'hFF, 8'hFF, 1'b1);
    wait_done8(lat);
    n_checks++;
    if (lat !== 8 || {carry8, sum8} !== 9'h1FF) begin
      n_fail++;
      $display("FAIL carry_ff_ff_1: got lat=%0d c=%b s=%h want 8 1 ff", lat, carry8, sum8);
    end
    finish_op8();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    start_op8(8'hA5, 8'h3C, 1'b0);
    wait_done8(lat);
    @(negedge clk);
    a_in8 = 8'h11; b_in8 = 8'h22; in_valid8 = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid8 !== 1'b1 || {carry8, sum8} !== 9'h0E1 || in_ready8 !== 1'b0) bad++;
    end
    n_checks++;
    if (lat !== 8 || bad !== 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: got lat=%0d unstable_cycles=%0d want 8 0", lat, bad);
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    finish_op8();
    n_checks++;
    if (out_valid8 !== 1'b0 || state8 !== 2'd0 || in_ready8 !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: got vld=%b state=%0d rdy=%b want 0 0 1", out_valid8, state8, in_ready8);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen;
    start_op8(8'h55, 8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid8, busy8, in_ready8} !== 3'b000 || sum8 !== 8'h00 || state8 !== 2'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got vld/busy/rdy=%b sum=%h state=%0d want 000 00 0", {out_valid8, busy8, in_ready8}, sum8, state8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid8) seen++;
    end
    n_checks++;
    if (seen !== 0 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_after_release: got valid_cycles=%0d rdy=%b busy=%b want 0 1 0", seen, in_ready8, busy8);
    end
    start_op8(8'h12, 8'h34, 1'b0);
    wait_done8(lat);
    n_checks++;
    if (lat !== 8 || {carry8, sum8} !== 9'h046) begin
      n_fail++;
      $display("FAIL midrun_next_op: got lat=%0d c=%b s=%h want 8 0 46", lat, carry8, sum8);
    end
    finish_op8();
  endtask

  task automatic test_operand_change();
    int lat;
    start_op8(8'h3A, 8'h47, 1'b1);
    repeat (6) begin
      @(negedge clk);
      a_in8 = ~a_in8;
      b_in8 = b_in8 + 8'h11;
      cin8  = ~cin8;
    end
    wait_done8(lat);
    n_checks++;
    if (lat < 0 || {carry8, sum8} !== 9'h082) begin
      n_fail++;
      $display("FAIL operand_change: got lat=%0d c=%b s=%h want c=0 s=82", lat, carry8, sum8);
    end
    finish_op8();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ta[4];
    logic [7:0] tb[4];
    logic       tc[4];
    logic [8:0] te[4];
    int lat;
    ta = '{8'h80, 8'h01, 8'hC3, 8'h00};
    tb = '{8'h80, 8'hFE, 8'h3C, 8'h00};
    tc = '{1'b0,  1'b1,  1'b0,  1'b1};
    te = '{9'h100, 9'h100, 9'h0FF, 9'h001};
    out_ready8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_op8(ta[i], tb[i], tc[i]);
      wait_done8(lat);
      n_checks++;
      if (lat !== 8 || {carry8, sum8} !== te[i]) begin
        n_fail++;
        $display("FAIL b2b_op%0d: got lat=%0d c=%b s=%h want 8 %h", i, lat, carry8, sum8, te[i]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid8 !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_single_pulse%0d: got vld=%b want 0", i, out_valid8);
      end
    end
    out_ready8 = 1'b0;
  endtask

  task automatic test_width16();
    logic [15:0] va[8];
    logic [15:0] vb[8];
    logic        vc[8];
    logic [16:0] ve[8];
    logic [16:0] exp;
    int lat;
    int results;
    va = '{16'hFFFF, 16'h1234, 16'h8000, 16'hFFFF, 16'h0000, 16'hABCD, 16'h7FFF, 16'hF0F0};
    vb = '{16'h0001, 16'h4321, 16'h8000, 16'hFFFF, 16'h0000, 16'h1234, 16'h0001, 16'h0F0F};
    vc = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b0,     1'b0,     1'b1};
    ve = '{17'h10000, 17'h05555, 17'h10001, 17'h1FFFF, 17'h00001, 17'h0BE01, 17'h08000, 17'h10000};
    results = 0;
    for (int i = 0; i < 8; i++) begin
      repeat (i % 3) @(negedge clk);
      start_op16(va[i], vb[i], vc[i]);
      exp_q.push_back(ve[i]);
      wait_done16(lat);
      repeat ((i * 2) % 5) @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== 16 || out_valid16 !== 1'b1 || {carry16, sum16} !== exp) begin
        n_fail++;
        $display("FAIL w16_op%0d: got lat=%0d vld=%b c=%b s=%h want 16 1 %h", i, lat, out_valid16, carry16, sum16, exp);
      end
      if (out_valid16) results++;
      @(negedge clk);
      out_ready16 = 1'b1;
      @(posedge clk); #1;
      out_ready16 = 1'b0;
      n_checks++;
      if (out_valid16 !== 1'b0) begin
        n_fail++;
        $display("FAIL w16_dup%0d: got vld=%b after handshake want 0", i, out_valid16);
      end
    end
    n_checks++;
    if (results !== 8 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL w16_count: got results=%0d pending=%0d want 8 0", results, exp_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    in_valid8 = 1'b0; a_in8 = '0; b_in8 = '0; cin8 = 1'b0; out_ready8 = 1'b0;
    in_valid16 = 1'b0; a_in16 = '0; b_in16 = '0; cin16 = 1'b0; out_ready16 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid_run();
    test_operand_change();
    test_back_to_back();
    test_width16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
